// File: rtl/vga_pkg.sv
// Shared constants, pixel type and fetch-state encoding for the VGA pixel path.
package vga_pkg;
  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int V_PERIOD    = 525;
  localparam int H_PERIOD    = 800;
  localparam int SCALE_SHIFT = 2;
  localparam int SRC_W       = H_ACTIVE >> SCALE_SHIFT;
  localparam int SRC_H       = V_ACTIVE >> SCALE_SHIFT;
  localparam int ADDR_W      = 15;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } fetch_state_e;

  // row*SRC_W as shift-add (160 = 128 + 32), wrapped to the address width
  function automatic logic [ADDR_W-1:0] row_offset(input logic [6:0] row);
    return ADDR_W'({row, 7'b0}) + ADDR_W'({row, 5'b0});
  endfunction
endpackage

// File: rtl/vga_line_fetch_if.sv
// Avalon-style single-outstanding read port between the line fetcher and memory.
interface vga_line_fetch_if;
  import vga_pkg::*;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_RD;
  logic              MEM_WAIT;
  rgb565_t           MEM_RDATA;
  logic              MEM_RVALID;

  modport master (output MEM_ADDR, output MEM_RD,
                  input MEM_WAIT, input MEM_RDATA, input MEM_RVALID);
  modport slave  (input MEM_ADDR, input MEM_RD,
                  output MEM_WAIT, output MEM_RDATA, output MEM_RVALID);
endinterface

// File: rtl/vga_line_ram.sv
// One 160x16 line buffer: single write port, registered read port with a
// synchronous clear so blanked/reset pixels come out as zero.
module vga_line_ram
  import vga_pkg::*;
(
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [7:0] waddr_i,
  input  rgb565_t    wdata_i,
  input  logic [7:0] raddr_i,
  input  logic       rd_clr_i,
  output rgb565_t    rdata_o
);
  rgb565_t mem_q [SRC_W];
  rgb565_t rdata_q;

  // write port; contents survive reset
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // registered read, forced to zero when cleared
  always_ff @(posedge clk_i) begin
    if (rd_clr_i) rdata_q <= '0;
    else          rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/vga_line_fetch.sv
// Line fetcher: pulls 160-pixel source rows into ping-pong line buffers and
// replays each pixel 4x horizontally and each row 4x vertically.
module vga_line_fetch
  import vga_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [11:0]          HC,
  input  logic [11:0]          VC,
  input  logic [ADDR_W-1:0]    FB_BASE,
  vga_line_fetch_if.master     mem,
  output rgb565_t              PIX_RGB,
  output logic                 UNDERRUN,
  input  logic                 UNDERRUN_CLR
);
  localparam logic [11:0] H_ACT12  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT12  = 12'(V_ACTIVE);
  localparam logic [11:0] V_LAST12 = 12'(V_PERIOD - 1);
  localparam logic [11:0] SRC_H12  = 12'(SRC_H);
  localparam logic [7:0]  COL_LAST = 8'(SRC_W - 1);

  fetch_state_e      state_q, state_d;
  logic              disp_sel_q, disp_sel_d;
  logic              pix_sel_q;
  logic [6:0]        row_ptr_q, row_ptr_d;
  logic [7:0]        col_cnt_q, col_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              underrun_q, underrun_d;

  logic        active, busy, pre_slot, swap_slot, pre_go, swap_go, fetch_req, underrun_set;
  logic [11:0] nrow;
  logic [6:0]  req_row;
  logic        wr_en;
  logic [1:0]  ram_we;
  logic [7:0]  raddr;
  rgb565_t     ram_rd [2];

  // trigger decode: triggers only fire on the first pixel of a line
  always_comb begin
    active       = (HC < H_ACT12) && (VC < V_ACT12);
    busy         = (state_q != IDLE);
    pre_slot     = (HC == 12'd0) && (VC == V_LAST12);
    swap_slot    = (HC == 12'd0) && (VC < V_ACT12) && (VC[1:0] == 2'b00);
    nrow         = {2'b00, VC[11:2]} + 12'd1;
    pre_go       = pre_slot && !busy;
    swap_go      = swap_slot && !busy;
    fetch_req    = pre_go || (swap_go && (nrow < SRC_H12));
    req_row      = pre_slot ? 7'd0 : nrow[6:0];
    underrun_set = (pre_slot || swap_slot) && busy;
    // the swap takes effect on the very pixel that triggers it
    disp_sel_d   = disp_sel_q ^ swap_go;
    raddr        = active ? HC[9:2] : 8'd0;
  end

  // fetch FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // fetch FSM next-state: one read outstanding, REQ holds until accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fetch_req) state_d = REQ;
      REQ:     if (!mem.MEM_WAIT) state_d = DATA;
      DATA:    if (mem.MEM_RVALID) state_d = (col_cnt_q == COL_LAST) ? IDLE : REQ;
      default: state_d = IDLE;
    endcase
  end

  // fetch FSM outputs: request strobe, address and back-buffer write
  always_comb begin
    mem.MEM_RD   = (state_q == REQ);
    mem.MEM_ADDR = addr_q;
    wr_en        = (state_q == DATA) && mem.MEM_RVALID;
    ram_we       = '0;
    if (wr_en) ram_we[~disp_sel_q] = 1'b1;
  end

  // fetch datapath next-state; address only recomputed when (re)entering REQ
  always_comb begin
    row_ptr_d = row_ptr_q;
    col_cnt_d = col_cnt_q;
    base_d    = pre_go ? FB_BASE : base_q;
    if (state_q == IDLE && fetch_req) begin
      row_ptr_d = req_row;
      col_cnt_d = '0;
    end else if (wr_en && col_cnt_q != COL_LAST) begin
      col_cnt_d = col_cnt_q + 8'd1;
    end
    addr_d = (state_d == REQ) ? base_d + row_offset(row_ptr_d) + ADDR_W'(col_cnt_d) : addr_q;
  end

  // sticky underrun: a set event beats a simultaneous clear
  always_comb begin
    underrun_d = underrun_q;
    if (underrun_set)     underrun_d = 1'b1;
    else if (UNDERRUN_CLR) underrun_d = 1'b0;
  end

  // fetch datapath, buffer select and flag registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      row_ptr_q  <= '0;
      col_cnt_q  <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      disp_sel_q <= 1'b0;
      pix_sel_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      row_ptr_q  <= row_ptr_d;
      col_cnt_q  <= col_cnt_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      disp_sel_q <= disp_sel_d;
      pix_sel_q  <= disp_sel_d;
      underrun_q <= underrun_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_buf
    vga_line_ram u_ram (
      .clk_i   (CLK),
      .we_i    (ram_we[b]),
      .waddr_i (col_cnt_q),
      .wdata_i (mem.MEM_RDATA),
      .raddr_i (raddr),
      .rd_clr_i(RST || !active),
      .rdata_o (ram_rd[b])
    );
  end

  // both RAM outputs are registers; pix_sel_q is aligned with them
  assign PIX_RGB  = pix_sel_q ? ram_rd[1] : ram_rd[0];
  assign UNDERRUN = underrun_q;
endmodule

// File: doc/vga_line_fetch.md
Name: vga_line_fetch

Overview:
- Upstream pixel source for the VGA output stage.
- Reads a 160x120 RGB565 framebuffer from NIOS-side memory over an Avalon-style read port.
- Uses ping-pong line buffers and upscales 4x4 to 640x480.
- Emits one registered RGB565 word per pixel clock, indexed by the display timing counters.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- V_PERIOD, 525, total lines per frame; VC runs 0..V_PERIOD-1
- SRC_W, 160, source pixels per row (H_ACTIVE>>2)
- SRC_H, 120, source rows (V_ACTIVE>>2)
- ADDR_W, 15, memory word-address width

Ports:
- CLK  in  1  pixel clock; every register is on its rising edge
- RST  in  1  synchronous, active-high reset
- HC  in  12  horizontal pixel counter from timing generator
- VC  in  12  vertical line counter from timing generator
- FB_BASE  in  ADDR_W  framebuffer base word address
- MEM_ADDR  out  ADDR_W  read address
- MEM_RD  out  1  read request
- MEM_WAIT  in  1  waitrequest; the request is accepted when MEM_RD && !MEM_WAIT
- MEM_RDATA  in  16  read data (RGB565)
- MEM_RVALID  in  1  MEM_RDATA is valid this cycle
- PIX_RGB  out  16  pixel to the output stage ({R5,G6,B5})
- UNDERRUN  out  1  sticky flag: a fetch was not complete at swap time
- UNDERRUN_CLR  in  1  clears UNDERRUN

Behaviour:
- Reset values:
  - PIX_RGB=0, MEM_RD=0, MEM_ADDR=0, UNDERRUN=0.
  - FSM=IDLE, disp_sel=0, row_ptr=0, col_cnt=0.
  - Line-buffer RAM contents are not cleared.
- Buffers: two 160x16 RAMs. disp_sel selects the display buffer; the other is the back buffer.
- Pixel path:
  - If HC<H_ACTIVE and VC<V_ACTIVE, PIX_RGB <= disp_buf[HC>>2].
  - Otherwise PIX_RGB <= 0.
  - Latency: exactly 1 cycle.
- Fetch triggers, evaluated only when HC==0:
  - Prefetch: VC==V_PERIOD-1. Latch base <= FB_BASE and start fetching row 0 into the back buffer.
  - Swap: VC<V_ACTIVE and VC[1:0]==0.
    - If the FSM is IDLE: toggle disp_sel. Then, if (VC>>2)+1 < SRC_H, start fetching row (VC>>2)+1 into the new back buffer.
    - If the FSM is not IDLE: set UNDERRUN, do not swap, and drop the new fetch request. The running fetch continues to completion and the display repeats the old row.
  - Prefetch with the FSM busy: set UNDERRUN and drop the request.
- Fetch FSM:
  - IDLE: on a start request, row_ptr <= row, col_cnt <= 0; go to REQ.
  - REQ:
    - MEM_RD=1, MEM_ADDR=base + row_ptr*SRC_W + col_cnt (mod 2^ADDR_W).
    - Address and MEM_RD are held stable while MEM_WAIT=1.
    - On accept, go to DATA.
  - DATA:
    - MEM_RD=0. On MEM_RVALID, back_buf[col_cnt] <= MEM_RDATA.
    - If col_cnt==SRC_W-1, go to IDLE; otherwise col_cnt++ and go to REQ.
    - MEM_RVALID seen outside DATA is ignored.
  - Only one read is outstanding at a time.
  - Budget: 4 lines (3200 cycles) per row, i.e. 160 reads with up to about 18 cycles each of combined wait and latency.
- UNDERRUN:
  - UNDERRUN_CLR clears it.
  - A set event in the same cycle as UNDERRUN_CLR wins (the flag stays 1).
- Reset mid-fetch: the FSM returns to IDLE immediately; any later MEM_RVALID for the in-flight read is ignored. Output may show stale data until the next prefetch.
- HC/VC values outside their ranges are not checked; output is 0 outside the active region.
- row*SRC_W: a constant multiply, implemented as (row<<7)+(row<<5).

Decomposition:
- Shared package vga_pkg:
  - Constants: H_ACTIVE, V_ACTIVE, V_PERIOD, H_PERIOD=800, SCALE_SHIFT=2.
  - Typedef for rgb565 and the fetch-state enum (IDLE/REQ/DATA).
- Sub-module vga_line_ram: single 160x16 RAM, one write port and one registered read port. Instantiated twice.

Test Plan:
- Frame-start prefetch: memory at FB_BASE=0x0100 holds word = address, MEM_WAIT=0, RVALID 2 cycles after accept, VC=524/HC=0 → 160 reads at 0x0100..0x019F. At VC=0, PIX_RGB over HC=0..3 is 0x0100 (1 cycle late), over HC=4..7 is 0x0101.
- Row advance: at VC=4/HC=0, disp_sel toggles. Lines 4..7 show words 0x01A0.. and the fetch of row 2 starts at 0x0240. VC=476 issues no new fetch.
- Wait-state handshake: MEM_WAIT=1 for 3 cycles on every request → MEM_ADDR and MEM_RD held stable. Fetch completes, UNDERRUN=0.
- Underrun: RVALID latency 25 cycles → fetch unfinished at VC=4. UNDERRUN=1, rows 0 stays displayed on lines 4..7, and the row-1 fetch still completes.
- UNDERRUN_CLR pulse with no event → UNDERRUN=0. Clear in the same cycle as a set event → UNDERRUN=1.
- RST asserted during REQ with col_cnt=50 → next cycle MEM_RD=0, PIX_RGB=0, UNDERRUN=0; a late RVALID leaves the buffers unchanged.
